// File: rtl/top.sv
// ---------------------------------------------------------------------------
// top -- eight-lane 32-bit SIMD processing element with running accumulators.
//
// Each rising clk edge takes eight 32-bit input lanes plus a 2-bit opcode and
// computes one result per lane. The opcode selects pass, accumulate,
// neighbour XOR mix or byte reverse. The edge also updates three running
// values: the sum of all inputs, the XOR checksum of all results and an edge
// counter.
//
// Ports
//   clk       in   1    sole clock, rising edge
//   rst_n     in   1    asynchronous active-low reset; clears every register
//   in_flat   in   258  [255:0] eight lanes (lane i at [32i+31:32i]),
//                       [257:256] opcode
//   out_flat  out  330  [255:0] lane results R0..R7, [287:256] acc,
//                       [319:288] chk, [327:320] cnt, [329:328] op_q
//
// Every out_flat bit comes straight from a register. There is no
// combinational path from in_flat to out_flat.
// ---------------------------------------------------------------------------
module top (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [257:0] in_flat,
  output logic [329:0] out_flat
);

  localparam int NUM_LANES = 8;

  localparam logic [1:0] OP_PASS = 2'b00;
  localparam logic [1:0] OP_ACC  = 2'b01;
  localparam logic [1:0] OP_MIX  = 2'b10;
  localparam logic [1:0] OP_BREV = 2'b11;

  logic [1:0]  op;
  logic [31:0] lane_in   [NUM_LANES];
  logic [31:0] lane_reg  [NUM_LANES];
  logic [31:0] lane_next [NUM_LANES];

  logic [31:0] acc_reg;
  logic [31:0] acc_next;
  logic [31:0] chk_reg;
  logic [31:0] chk_next;
  logic [7:0]  cnt_reg;
  logic [7:0]  cnt_next;
  logic [1:0]  op_q_reg;

  assign op = in_flat[257:256];

  // Per-lane datapath
  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      // Lane 7 wraps around and mixes with lane 0.
      localparam int NB = (gi + 1) % NUM_LANES;

      assign lane_in[gi] = in_flat[32*gi +: 32];

      always_comb begin
        lane_next[gi] = lane_in[gi];
        case (op)
          OP_PASS: lane_next[gi] = lane_in[gi];
          OP_ACC:  lane_next[gi] = lane_reg[gi] + lane_in[gi];
          OP_MIX:  lane_next[gi] = lane_in[gi] ^ lane_in[NB];
          OP_BREV: lane_next[gi] = {lane_in[gi][7:0],   lane_in[gi][15:8],
                                    lane_in[gi][23:16], lane_in[gi][31:24]};
          default: lane_next[gi] = lane_in[gi];
        endcase
      end

      assign out_flat[32*gi +: 32] = lane_reg[gi];
    end
  endgenerate

  // Running sum of the raw inputs. This does not depend on op.
  // The checksum uses the new lane results, not the registered ones.
  always_comb begin
    acc_next = acc_reg;
    chk_next = chk_reg;
    for (int i = 0; i < NUM_LANES; i++) begin
      acc_next = acc_next + lane_in[i];
      chk_next = chk_next ^ lane_next[i];
    end
  end

  assign cnt_next = cnt_reg + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_reg[i] <= '0;
      end
      acc_reg  <= '0;
      chk_reg  <= '0;
      cnt_reg  <= '0;
      op_q_reg <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_reg[i] <= lane_next[i];
      end
      acc_reg  <= acc_next;
      chk_reg  <= chk_next;
      cnt_reg  <= cnt_next;
      op_q_reg <= op;
    end
  end

  assign out_flat[287:256] = acc_reg;
  assign out_flat[319:288] = chk_reg;
  assign out_flat[327:320] = cnt_reg;
  assign out_flat[329:328] = op_q_reg;

endmodule

// File: tb/tb_top.sv
// ---------------------------------------------------------------------------
// tb_top -- directed and random checks for top.
// Inputs change on the falling edge. A reference model predicts each result
// and pushes it into a queue. One time unit after the next rising edge the
// bench pops that prediction and compares it with out_flat. Directed steps
// also check individual fields against hand-computed constants.
// ---------------------------------------------------------------------------
module tb_top;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [257:0] in_flat;
  logic [329:0] out_flat;

  int pass_cnt  = 0;
  int total_cnt = 0;

  logic [329:0] exp_q[$];

  // Reference model state
  logic [31:0] m_lane [8];
  logic [31:0] m_acc;
  logic [31:0] m_chk;
  logic [7:0]  m_cnt;
  logic [1:0]  m_op;

  top dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_flat  (in_flat),
    .out_flat (out_flat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [329:0] obs, input logic [329:0] exp);
    total_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_lane[i] = '0;
    m_acc = '0;
    m_chk = '0;
    m_cnt = '0;
    m_op  = '0;
  endtask

  function automatic logic [329:0] model_pack();
    logic [329:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = m_lane[i];
    v[287:256] = m_acc;
    v[319:288] = m_chk;
    v[327:320] = m_cnt;
    v[329:328] = m_op;
    return v;
  endfunction

  task automatic model_apply(input logic [257:0] v);
    logic [31:0] a [8];
    logic [31:0] l [8];
    logic [1:0]  op;
    op = v[257:256];
    for (int i = 0; i < 8; i++) a[i] = v[32*i +: 32];
    for (int i = 0; i < 8; i++) begin
      if (op == 2'd0)      l[i] = a[i];
      else if (op == 2'd1) l[i] = m_lane[i] + a[i];
      else if (op == 2'd2) l[i] = a[i] ^ a[(i + 1) % 8];
      else                 l[i] = {<<8{a[i]}};
    end
    for (int i = 0; i < 8; i++) begin
      m_acc = m_acc + a[i];
      m_chk = m_chk ^ l[i];
      m_lane[i] = l[i];
    end
    m_cnt = m_cnt + 8'd1;
    m_op  = op;
  endtask

  // Called at a falling edge. Returns at the following falling edge.
  task automatic step(input logic [257:0] v);
    logic [329:0] exp;
    in_flat = v;
    model_apply(v);
    exp_q.push_back(model_pack());
    @(posedge clk);
    #1;
    exp = exp_q.pop_front();
    check("scoreboard", out_flat, exp);
    @(negedge clk);
  endtask

  // Called at a falling edge. Asserts reset mid-cycle, checks the zero state,
  // holds reset across an edge with junk inputs, then releases it.
  task automatic do_reset(input string tag);
    #2;
    rst_n   = 1'b0;
    in_flat = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
               $urandom, $urandom, $urandom};
    #1;
    check(tag, out_flat, 330'd0);
    @(posedge clk);
    #1;
    check("reset_hold", out_flat, 330'd0);
    model_clear();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  function automatic logic [257:0] lanes_op(input logic [31:0] l [8], input logic [1:0] op);
    logic [257:0] v;
    for (int i = 0; i < 8; i++) v[32*i +: 32] = l[i];
    v[257:256] = op;
    return v;
  endfunction

  initial begin
    logic [31:0]  lanes [8];
    logic [257:0] v;

    rst_n   = 1'b1;
    in_flat = '0;
    model_clear();

    // Reset is asserted before any clock edge, so the zero state must
    // appear without an edge.
    #1;
    rst_n   = 1'b0;
    in_flat = {258{1'b1}};
    #1;
    check("reset_async", out_flat, 330'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // All lanes = 1, op pass
    for (int i = 0; i < 8; i++) lanes[i] = 32'd1;
    step(lanes_op(lanes, 2'd0));
    for (int i = 0; i < 8; i++)
      check($sformatf("ones_R%0d", i), {298'd0, out_flat[32*i +: 32]}, 330'd1);
    check("ones_acc",  {298'd0, out_flat[287:256]}, 330'd8);
    check("ones_chk",  {298'd0, out_flat[319:288]}, 330'd0);
    check("ones_cnt",  {322'd0, out_flat[327:320]}, 330'd1);
    check("ones_op_q", {328'd0, out_flat[329:328]}, 330'd0);

    // Accumulate wrap
    do_reset("reset_acc");
    for (int i = 0; i < 8; i++) lanes[i] = 32'd0;
    lanes[0] = 32'hFFFF_FFFF;
    step(lanes_op(lanes, 2'd1));
    check("accw_R0_1",  {298'd0, out_flat[31:0]},    {298'd0, 32'hFFFF_FFFF});
    check("accw_acc_1", {298'd0, out_flat[287:256]}, {298'd0, 32'hFFFF_FFFF});
    step(lanes_op(lanes, 2'd1));
    check("accw_R0_2",  {298'd0, out_flat[31:0]},    {298'd0, 32'hFFFF_FFFE});
    check("accw_acc_2", {298'd0, out_flat[287:256]}, {298'd0, 32'hFFFF_FFFE});

    // Neighbour mix
    do_reset("reset_mix");
    for (int i = 0; i < 8; i++) lanes[i] = 32'h1111_1111 * (i + 1);
    step(lanes_op(lanes, 2'd2));
    check("mix_R0", {298'd0, out_flat[31:0]},    {298'd0, 32'h3333_3333});
    check("mix_R7", {298'd0, out_flat[255:224]}, {298'd0, 32'h9999_9999});

    // Byte reverse
    do_reset("reset_brev");
    for (int i = 0; i < 8; i++) lanes[i] = 32'd0;
    lanes[3] = 32'h1234_5678;
    step(lanes_op(lanes, 2'd3));
    check("brev_R3",   {298'd0, out_flat[127:96]},  {298'd0, 32'h7856_3412});
    check("brev_chk",  {298'd0, out_flat[319:288]}, {298'd0, 32'h7856_3412});
    check("brev_op_q", {328'd0, out_flat[329:328]}, 330'd3);

    // Random run of 256 edges. This also covers the counter wrap.
    do_reset("reset_soak");
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
      v[257:256] = 2'($urandom_range(0, 3));
      step(v);
    end
    check("cnt_wrap", {322'd0, out_flat[327:320]}, 330'd0);
    do_reset("reset_midrun");

    // The first edge after reset works from the zero state.
    for (int i = 0; i < 8; i++) lanes[i] = 32'h0101_0101 << i;
    step(lanes_op(lanes, 2'd1));

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/top.md
TOP -- requirements
Module: top

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_flat  input  258  [255:0] = eight 32-bit lanes; lane i = in_flat[32i+31:32i]; [257:256] = opcode op.
REQ-005 out_flat  output  330  fields are packed as follows:
- [255:0] = registered lane results R0..R7, with Ri at [32i+31:32i].
- [287:256] = acc.
- [319:288] = chk.
- [327:320] = cnt.
- [329:328] = op_q.
REQ-006 All out_flat bits SHALL be driven directly from registers, with no combinational path from in_flat to out_flat.

Function
REQ-007 Every rising clk edge with rst_n=1 SHALL update all state from the in_flat value sampled at that edge; latency is 1 cycle.
REQ-008 Lane result Li SHALL be computed from lane i (Ai) and the current register Ri according to op:
- op=00 pass: Li = Ai.
- op=01 accumulate: Li = (Ri + Ai) mod 2^32.
- op=10 neighbour mix: Li = Ai XOR A((i+1) mod 8), so lane 7 mixes with lane 0.
- op=11 byte reverse: Li = {Ai[7:0], Ai[15:8], Ai[23:16], Ai[31:24]}.
REQ-009 Ri SHALL load Li on each edge.
REQ-010 acc SHALL load (acc + A0 + A1 + ... + A7) mod 2^32 on each edge, independent of op; carries beyond bit 31 are discarded.
REQ-011 chk SHALL load chk XOR L0 XOR L1 XOR ... XOR L7, using the new lane results.
REQ-012 cnt SHALL increment by 1 on each edge and wrap from 255 to 0.
REQ-013 op_q SHALL load in_flat[257:256].
REQ-014 Arithmetic SHALL be unsigned, and all sums SHALL be truncated to their field width.
REQ-015 X-free operation: once reset is applied, no output bit SHALL be X or Z.

Reset
REQ-016 When rst_n=0, all registers (R0..R7, acc, chk, cnt, op_q) SHALL clear to 0 immediately, without waiting for a clock edge.
REQ-017 While rst_n=0, all registers SHALL hold 0 and in_flat SHALL be ignored.
REQ-018 A reset asserted mid-operation SHALL discard all accumulated state.
REQ-019 The first edge after rst_n rises SHALL perform a normal update from the zero state.

Verification
REQ-020 Reset: drive rst_n=0 with arbitrary in_flat -> out_flat = 0 with no clock edge needed; release, then one edge with all lanes=1 and op=00 -> every Ri=1, acc=8, chk=0 (eight 1s XOR to 0), cnt=1, op_q=0.
REQ-021 Accumulate wrap: lane0=0xFFFFFFFF, other lanes 0, op=01, applied for two edges from reset -> R0=0xFFFFFFFF then 0xFFFFFFFE; acc=0xFFFFFFFF then 0xFFFFFFFE.
REQ-022 Neighbour mix: lanes = 0x11111111 times (i+1), i.e. 0x11111111, 0x22222222, ..., op=10, applied for one edge from reset -> R0=0x33333333 and R7=0x88888888 XOR 0x11111111 = 0x99999999.
REQ-023 Byte reverse: lane3=0x12345678, other lanes 0, op=11, applied for one edge from reset -> R3=0x78563412, chk=0x78563412, op_q=3.
REQ-024 Counter wrap: run 256 edges after reset -> cnt reads 0; then assert rst_n=0 mid-cycle -> all fields read 0 immediately.
REQ-025 Random soak: compare against a reference model for 100+ cycles under random in_flat, updating inputs on the negedge -> exact out_flat match every cycle.
